// File: rtl/gate_exerciser.sv
// -----------------------------------------------------------------------------
// gate_exerciser
//
// Self-test stimulus/response stage for the two-input basic-gate block.
// On an accepted start it walks the gate block's {a,b} inputs through
// 00 -> 01 -> 10 -> 11, PASSES times over. Each vector is held for
// HOLD_CYCLES cycles. On the last cycle of each hold window it compares the
// seven returned gate outputs with a hard-wired truth table. It then reports
// pass/fail, a saturating error count, sticky per-vector fail flags and the
// most recent failing vector/response.
//
// Parameters
//   HOLD_CYCLES  cycles each vector is held before it is checked (1..255)
//   PASSES       full four-vector sweeps per run (1..255)
//
// Ports
//   i_clk            rising-edge clock
//   i_rst            asynchronous active-high reset
//   i_start          run request, only honoured while idle
//   i_gate_in[6:0]   gate outputs {xnor,xor,nor,nand,or,and,b_not}
//   o_a, o_b         registered gate inputs
//   o_busy           run in progress
//   o_done           one-cycle end-of-run pulse
//   o_pass           last completed run saw zero mismatches
//   o_err_count[7:0] mismatching samples in current/last run (saturating)
//   o_fail_mask[3:0] sticky fail flag per vector {a,b}
//   o_last_fail_vec  {a,b} of the most recent mismatch
//   o_last_fail_got  gate outputs captured at the most recent mismatch
// -----------------------------------------------------------------------------
module gate_exerciser #(
    parameter int HOLD_CYCLES = 4,
    parameter int PASSES      = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [6:0] i_gate_in,
    output logic       o_a,
    output logic       o_b,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [7:0] o_err_count,
    output logic [3:0] o_fail_mask,
    output logic [1:0] o_last_fail_vec,
    output logic [6:0] o_last_fail_got
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Terminal counts, computed once so the compares stay 8 bits wide.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] PASS_LAST = 8'(PASSES - 1);

    // Golden response of a healthy gate block for input vector {a,b}.
    // Bit order: 0 b_not, 1 and, 2 or, 3 nand, 4 nor, 5 xor, 6 xnor.
    function automatic logic [6:0] expected_outputs(input logic [1:0] vec);
        logic [6:0] exp_v;
        case (vec)
            2'b00:   exp_v = 7'h59;
            2'b01:   exp_v = 7'h2C;
            2'b10:   exp_v = 7'h2D;
            2'b11:   exp_v = 7'h46;
            default: exp_v = 7'h00;
        endcase
        return exp_v;
    endfunction

    state_t     r_state;
    logic [7:0] r_hold_cnt;
    logic [7:0] r_pass_cnt;
    logic [1:0] r_vec;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [7:0] r_err_count;
    logic [3:0] r_fail_mask;
    logic [1:0] r_last_fail_vec;
    logic [6:0] r_last_fail_got;

    logic       w_sample;
    logic       w_mismatch;
    logic       w_last_sample;
    logic [7:0] w_err_next;

    // Sample strobe, compare result and next error count for the current edge.
    always_comb begin
        w_sample      = 1'b0;
        w_mismatch    = 1'b0;
        w_last_sample = 1'b0;
        w_err_next    = r_err_count;
        if ((r_state == ST_DRIVE) && (r_hold_cnt == HOLD_LAST)) begin
            w_sample = 1'b1;
        end else begin
            w_sample = 1'b0;
        end
        if (w_sample && (i_gate_in != expected_outputs(r_vec))) begin
            w_mismatch = 1'b1;
        end else begin
            w_mismatch = 1'b0;
        end
        // The compare on vector 11 of the final sweep ends the run.
        if (w_sample && (r_vec == 2'b11) && (r_pass_cnt == PASS_LAST)) begin
            w_last_sample = 1'b1;
        end else begin
            w_last_sample = 1'b0;
        end
        // Error count saturates at 255 so a long faulty run cannot wrap to "pass".
        if (w_mismatch && (r_err_count != 8'hFF)) begin
            w_err_next = r_err_count + 8'd1;
        end else begin
            w_err_next = r_err_count;
        end
    end

    // Run-control FSM with all result and stimulus registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_hold_cnt      <= 8'd0;
            r_pass_cnt      <= 8'd0;
            r_vec           <= 2'b00;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_err_count     <= 8'd0;
            r_fail_mask     <= 4'b0000;
            r_last_fail_vec <= 2'b00;
            r_last_fail_got <= 7'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state         <= ST_DRIVE;
                        r_vec           <= 2'b00;
                        r_hold_cnt      <= 8'd0;
                        r_pass_cnt      <= 8'd0;
                        r_busy          <= 1'b1;
                        r_pass          <= 1'b0;
                        r_err_count     <= 8'd0;
                        r_fail_mask     <= 4'b0000;
                        r_last_fail_vec <= 2'b00;
                        r_last_fail_got <= 7'h00;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_DRIVE: begin
                    if (!w_sample) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end else begin
                        r_hold_cnt  <= 8'd0;
                        r_err_count <= w_err_next;
                        if (w_mismatch) begin
                            r_fail_mask[r_vec] <= 1'b1;
                            r_last_fail_vec    <= r_vec;
                            r_last_fail_got    <= i_gate_in;
                        end else begin
                            r_last_fail_vec <= r_last_fail_vec;
                        end
                        if (w_last_sample) begin
                            // Pass flag includes the compare made on this same edge.
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_vec   <= 2'b00;
                            r_pass  <= (w_err_next == 8'd0);
                        end else begin
                            r_vec <= r_vec + 2'd1;
                            if (r_vec == 2'b11) begin
                                r_pass_cnt <= r_pass_cnt + 8'd1;
                            end else begin
                                r_pass_cnt <= r_pass_cnt;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_vec   <= 2'b00;
                end
            endcase
        end
    end

    assign o_a             = r_vec[1];
    assign o_b             = r_vec[0];
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_pass          = r_pass;
    assign o_err_count     = r_err_count;
    assign o_fail_mask     = r_fail_mask;
    assign o_last_fail_vec = r_last_fail_vec;
    assign o_last_fail_got = r_last_fail_got;

endmodule

// File: tb/tb_gate_exerciser.sv
// -----------------------------------------------------------------------------
// tb_gate_exerciser
//
// Directed bench for gate_exerciser. Three instances cover the parameter
// sets of interest (HOLD=4/PASSES=1, HOLD=2/PASSES=3, HOLD=1/PASSES=1). Each
// one is fed by a behavioural gate model with a selectable planted fault.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_gate_exerciser;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    // Fault codes: 0 healthy, 1 and stuck-0, 2 xor/xnor swapped, 3 nor stuck-1.
    function automatic logic [6:0] gate_model(input logic a, input logic b,
                                              input logic [1:0] fault);
        logic [6:0] g;
        g[0] = ~b;
        g[1] = a & b;
        g[2] = a | b;
        g[3] = ~(a & b);
        g[4] = ~(a | b);
        g[5] = a ^ b;
        g[6] = ~(a ^ b);
        case (fault)
            2'd1: g[1] = 1'b0;
            2'd2: begin
                g[5] = ~(a ^ b);
                g[6] = a ^ b;
            end
            2'd3: g[4] = 1'b1;
            default: g[0] = g[0];
        endcase
        return g;
    endfunction

    // Single comparison point: counts every check, reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- instance A: HOLD=4, PASSES=1 ----------------
    logic       start_a, a_a, b_a, busy_a, done_a, pass_a;
    logic [6:0] gin_a, got_a;
    logic [7:0] err_a;
    logic [3:0] mask_a;
    logic [1:0] vec_a, fault_a;

    always_comb gin_a = gate_model(a_a, b_a, fault_a);

    gate_exerciser #(.HOLD_CYCLES(4), .PASSES(1)) u_h4 (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_gate_in(gin_a),
        .o_a(a_a), .o_b(b_a), .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
        .o_err_count(err_a), .o_fail_mask(mask_a), .o_last_fail_vec(vec_a),
        .o_last_fail_got(got_a)
    );

    // ---------------- instance B: HOLD=2, PASSES=3 ----------------
    logic       start_b, a_b, b_b, busy_b, done_b, pass_b;
    logic [6:0] gin_b, got_b;
    logic [7:0] err_b;
    logic [3:0] mask_b;
    logic [1:0] vec_b, fault_b;

    always_comb gin_b = gate_model(a_b, b_b, fault_b);

    gate_exerciser #(.HOLD_CYCLES(2), .PASSES(3)) u_p3 (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_gate_in(gin_b),
        .o_a(a_b), .o_b(b_b), .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
        .o_err_count(err_b), .o_fail_mask(mask_b), .o_last_fail_vec(vec_b),
        .o_last_fail_got(got_b)
    );

    // ---------------- instance C: HOLD=1, PASSES=1 ----------------
    logic       start_c, a_c, b_c, busy_c, done_c, pass_c;
    logic [6:0] gin_c, got_c;
    logic [7:0] err_c;
    logic [3:0] mask_c;
    logic [1:0] vec_c, fault_c;

    always_comb gin_c = gate_model(a_c, b_c, fault_c);

    gate_exerciser #(.HOLD_CYCLES(1), .PASSES(1)) u_h1 (
        .i_clk(clk), .i_rst(rst), .i_start(start_c), .i_gate_in(gin_c),
        .o_a(a_c), .o_b(b_c), .o_busy(busy_c), .o_done(done_c), .o_pass(pass_c),
        .o_err_count(err_c), .o_fail_mask(mask_c), .o_last_fail_vec(vec_c),
        .o_last_fail_got(got_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start a run on instance A and return the edge count until done (bounded).
    task automatic run_a(output int lat);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        lat = 0;
        while (!done_a && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int m;
        bit saw_done;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        start_c  = 1'b0;
        fault_a  = 2'd0;
        fault_b  = 2'd0;
        fault_c  = 2'd0;
        tick();
        tick();

        // Reset state.
        check_eq("rst_ab",   32'({a_a, b_a}), 32'd0);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_done", 32'(done_a), 32'd0);
        check_eq("rst_pass", 32'(pass_a), 32'd0);
        check_eq("rst_err",  32'(err_a),  32'd0);
        check_eq("rst_mask", 32'(mask_a), 32'd0);
        check_eq("rst_vec",  32'(vec_a),  32'd0);
        check_eq("rst_got",  32'(got_a),  32'd0);
        rst = 1'b0;
        tick();

        // Healthy gate, HOLD=4: step sequence and done timing.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_eq("h_busy0", 32'(busy_a), 32'd1);
        check_eq("h_ab0",   32'({a_a, b_a}), 32'd0);
        for (int n = 1; n < 16; n++) begin
            tick();
            check_eq("h_ab",   32'({a_a, b_a}), 32'(n / 4));
            check_eq("h_busy", 32'(busy_a), 32'd1);
            check_eq("h_done", 32'(done_a), 32'd0);
        end
        tick();
        check_eq("h_done16", 32'(done_a), 32'd1);
        check_eq("h_busy16", 32'(busy_a), 32'd0);
        check_eq("h_pass",   32'(pass_a), 32'd1);
        check_eq("h_err",    32'(err_a),  32'd0);
        check_eq("h_mask",   32'(mask_a), 32'd0);
        check_eq("h_ab16",   32'({a_a, b_a}), 32'd0);
        tick();
        check_eq("h_done17", 32'(done_a), 32'd0);
        check_eq("h_hold",   32'(pass_a), 32'd1);

        // and stuck at 0: only vector 11 fails.
        fault_a = 2'd1;
        run_a(lat);
        check_eq("and_lat",  32'(lat),    32'd16);
        check_eq("and_err",  32'(err_a),  32'd1);
        check_eq("and_mask", 32'(mask_a), 32'h8);
        check_eq("and_vec",  32'(vec_a),  32'd3);
        check_eq("and_got",  32'(got_a),  32'h44);
        check_eq("and_pass", 32'(pass_a), 32'd0);
        tick();

        // xor/xnor swapped: every vector fails.
        fault_a = 2'd2;
        run_a(lat);
        check_eq("sw_lat",  32'(lat),    32'd16);
        check_eq("sw_err",  32'(err_a),  32'd4);
        check_eq("sw_mask", 32'(mask_a), 32'hF);
        check_eq("sw_vec",  32'(vec_a),  32'd3);
        check_eq("sw_got",  32'(got_a),  32'h26);
        check_eq("sw_pass", 32'(pass_a), 32'd0);
        tick();

        // PASSES=3, HOLD=2, nor stuck at 1.
        fault_b = 2'd3;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        lat = 0;
        while (!done_b && lat < 200) begin
            tick();
            lat++;
        end
        check_eq("nor_lat",  32'(lat),    32'd24);
        check_eq("nor_err",  32'(err_b),  32'd9);
        check_eq("nor_mask", 32'(mask_b), 32'hE);
        check_eq("nor_vec",  32'(vec_b),  32'd3);
        check_eq("nor_got",  32'(got_b),  32'h56);
        check_eq("nor_pass", 32'(pass_b), 32'd0);
        check_eq("nor_busy", 32'(busy_b), 32'd0);
        tick();

        // Reset mid-run: outputs clear asynchronously, no done pulse.
        fault_a = 2'd2;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        check_eq("mr_err_pre", 32'(err_a), 32'd1);
        check_eq("mr_ab_pre",  32'({a_a, b_a}), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("mr_ab",   32'({a_a, b_a}), 32'd0);
        check_eq("mr_busy", 32'(busy_a), 32'd0);
        check_eq("mr_err",  32'(err_a),  32'd0);
        check_eq("mr_mask", 32'(mask_a), 32'd0);
        check_eq("mr_got",  32'(got_a),  32'd0);
        repeat (3) tick();
        rst = 1'b0;
        saw_done = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (done_a || busy_a) saw_done = 1'b1;
        end
        check_eq("mr_nodone", 32'(saw_done), 32'd0);
        fault_a = 2'd0;
        run_a(lat);
        check_eq("mr_lat",  32'(lat),    32'd16);
        check_eq("mr_pass", 32'(pass_a), 32'd1);
        check_eq("mr_err2", 32'(err_a),  32'd0);
        tick();

        // start held with HOLD=1, faulty xor/xnor: back-to-back 6-cycle runs.
        fault_c = 2'd2;
        start_c = 1'b1;
        tick();
        for (int k = 0; k < 18; k++) begin
            m = k % 6;
            if (k > 0) tick();
            check_eq("bb_done", 32'(done_c), 32'(m == 4));
            check_eq("bb_busy", 32'(busy_c), 32'(m < 4));
            check_eq("bb_ab",   32'({a_c, b_c}), (m < 4) ? 32'(m) : 32'd0);
            check_eq("bb_err",  32'(err_c),  (m < 4) ? 32'(m) : 32'd4);
        end
        start_c = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_exerciser.md
# gate_exerciser

Self-checking stimulus/response stage that wraps the two-input basic-gate block. On `start` it drives the gate block's `a`/`b` inputs through all four input combinations, one or more times, and holds each vector for a programmable number of cycles. At the end of each hold window it samples the seven gate outputs against a hard-wired truth table. It then reports pass/fail, an error count and diagnostic capture. It sits directly upstream of the gate block (feeding `a`, `b`) and consumes that block's outputs, allowing in-circuit self-test without a testbench.

## Interface
- `HOLD_CYCLES`, 4: cycles each input vector is held before its outputs are checked; legal range 1–255.
- `PASSES`, 1: number of full 00→01→10→11 sweeps per run; legal range 1–255.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `gate_in`  in  7  gate outputs: bit0 b_not, bit1 and, bit2 or, bit3 nand, bit4 nor, bit5 xor, bit6 xnor.
- `a`  out  1  gate input a (registered).
- `b`  out  1  gate input b (registered).
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  result of last completed run; 1 = zero mismatches.
- `err_count`  out  8  mismatching samples in the current/last run; saturates at 255.
- `fail_mask`  out  4  sticky per-vector fail flags; bit i = vector {a,b}=i failed at least once.
- `last_fail_vec`  out  2  {a,b} of the most recent mismatch.
- `last_fail_got`  out  7  `gate_in` captured at the most recent mismatch.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE, `start`=1 at an edge:
  - go to DRIVE; {a,b}<=00; hold counter<=0; pass counter<=0; busy<=1.
  - clear err_count, fail_mask, last_fail_vec, last_fail_got and pass.
- DRIVE, each edge:
  - If hold counter ≠ HOLD_CYCLES−1: increment the hold counter.
  - Else: compare `gate_in` with the expected value for the current {a,b}, reset the hold counter to 0, and advance {a,b} by 1 (11 wraps to 00).
  - If the compare was on vector 11 of the final pass: go to DONE instead.
- Expected `gate_in` per vector:
  - 00 → 7'h59
  - 01 → 7'h2C
  - 10 → 7'h2D
  - 11 → 7'h46
- Mismatch: err_count+1 (saturating at 255); fail_mask[vec]<=1; last_fail_vec<=vec; last_fail_got<=gate_in.
- Entering DONE: done<=1, busy<=0, {a,b}<=00, pass<=(final err_count==0), including the compare made on that same edge.
- DONE lasts exactly one cycle, then returns to IDLE; done<=0.
- `start` in DRIVE or DONE is ignored. A `start` held continuously launches a new run on the first IDLE edge.
- Result registers hold their values until the next accepted `start`.

## Timing
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, last_fail_vec=0, last_fail_got=0; state IDLE; all counters 0.
- Reset asserted mid-run: outputs go to reset values immediately (asynchronous) and the run is abandoned. Operation resumes with IDLE semantics on the first edge after deassertion.
- Accepted `start` at edge e0:
  - vector k of pass p is visible on a/b from edge e0+(4p+k)·HOLD_CYCLES.
  - that vector is sampled at edge e0+(4p+k+1)·HOLD_CYCLES.
- Run length: done is high during the cycle after edge e0+4·PASSES·HOLD_CYCLES. The next `start` is accepted at edge e0+4·PASSES·HOLD_CYCLES+2.
- `gate_in` is treated as a combinational function of a/b and must settle within HOLD_CYCLES cycles. With HOLD_CYCLES=1 it must settle within the same cycle.
- `done` and `busy` never overlap.

## Test plan
- Correct gate model, HOLD=4, PASSES=1, start at e0:
  - a/b steps 00,01,10,11 each for 4 cycles.
  - done pulses after e16, busy low from then.
  - pass=1, err_count=0, fail_mask=0.
- and-output stuck at 0, HOLD=4:
  - only vector 11 fails.
  - err_count=1, fail_mask=4'b1000, last_fail_vec=2'b11, last_fail_got=7'h44, pass=0.
- xor and xnor swapped:
  - all vectors fail; err_count=4, fail_mask=4'b1111.
  - last_fail_vec=11, last_fail_got=7'h26.
- PASSES=3, HOLD=2, nor stuck at 1:
  - done after edge 24; err_count=9 (vectors 01, 10, 11 each pass).
  - fail_mask=4'b1110.
- Reset mid-run:
  - rst pulse at cycle 6 → all outputs zero at once and no done pulse.
  - a subsequent start produces a clean full run with pass=1.
- start held high continuously with HOLD=1:
  - runs back-to-back; done pulses every 6 cycles.
  - start during busy has no effect; results clear at each new run start.
